// File: rtl/pwm_ramp_sequencer.sv
// Ramps the PWM duty from its present value toward a commanded target in fixed steps,
// updating only on PWM period boundaries and holding each step for a set number of periods.
module pwm_ramp_sequencer #(
  parameter int unsigned R         = 8,
  parameter int unsigned HOLD_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [R:0]           i_target_duty,
  input  logic [R-1:0]         i_step_size,
  input  logic [HOLD_BITS-1:0] i_hold_periods,
  input  logic                 i_abort,
  input  logic                 i_period_tick,
  output logic [R:0]           o_duty,
  output logic                 o_cmd_ready,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned DW      = R + 1;
  localparam int unsigned SW      = R;
  localparam int unsigned HW      = HOLD_BITS;
  localparam int unsigned AW      = R + 2;
  localparam int unsigned FULL_ON = 1 << R;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RAMP   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_duty;
  logic            r_busy;
  logic            r_cmd_ready;
  logic            r_done;
  logic [DW-1:0]   r_target;
  logic [SW-1:0]   r_step;
  logic [HW-1:0]   r_hold;
  logic [HW-1:0]   r_hold_cnt;

  logic [DW-1:0]   w_target_clamped;
  logic [SW-1:0]   w_step_eff;
  logic [HW-1:0]   w_hold_eff;
  logic [AW-1:0]   w_up_sum;
  logic [DW-1:0]   w_up_next;
  logic [DW-1:0]   w_dn_next;
  logic            w_ramp_up;
  logic [DW-1:0]   w_next_duty;

  // Command normalisation at accept: clamp target to full-on, zero step/hold act as one.
  always_comb begin
    w_target_clamped = (i_target_duty > DW'(FULL_ON)) ? DW'(FULL_ON) : i_target_duty;
    w_step_eff       = (i_step_size == '0) ? SW'(1) : i_step_size;
    w_hold_eff       = (i_hold_periods == '0) ? HW'(1) : i_hold_periods;
  end

  // Next step value, saturating at the target; AW-bit math cannot wrap past 0 or full-on.
  always_comb begin
    w_ramp_up   = (r_target > r_duty);
    w_up_sum    = AW'(r_duty) + AW'(r_step);
    w_up_next   = (w_up_sum >= AW'(r_target)) ? r_target : DW'(w_up_sum);
    w_dn_next   = (AW'(r_duty) >= (AW'(r_target) + AW'(r_step)))
                  ? DW'(AW'(r_duty) - AW'(r_step)) : r_target;
    w_next_duty = w_ramp_up ? w_up_next : w_dn_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_duty      <= '0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_done      <= 1'b0;
      r_target    <= '0;
      r_step      <= '0;
      r_hold      <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Abort on the same edge as start suppresses the command.
          if (i_start && !i_abort) begin
            r_target    <= w_target_clamped;
            r_step      <= w_step_eff;
            r_hold      <= w_hold_eff;
            r_hold_cnt  <= w_hold_eff;
            r_busy      <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= (w_target_clamped == r_duty) ? S_FINISH : S_RAMP;
          end
        end

        S_RAMP: begin
          if (i_abort) begin
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else if (i_period_tick) begin
            if (r_hold_cnt <= HW'(1)) begin
              r_duty     <= w_next_duty;
              r_hold_cnt <= r_hold;
              if (w_next_duty == r_target) begin
                r_state <= S_FINISH;
              end
            end else begin
              r_hold_cnt <= r_hold_cnt - HW'(1);
            end
          end
        end

        S_FINISH: begin
          r_done      <= !i_abort;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end

        default: begin
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_duty      = r_duty;
  assign o_busy      = r_busy;
  assign o_cmd_ready = r_cmd_ready;
  assign o_done      = r_done;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Bench for pwm_ramp_sequencer: directed scenarios plus random traffic against a
// closed-form model (duty = d0 +/- floor(ticks/hold)*step, saturated at target).
module tb_pwm_ramp_sequencer;

  localparam int unsigned R         = 8;
  localparam int unsigned HOLD_BITS = 8;
  localparam int          FULL      = 1 << R;

  logic                 i_clk = 1'b0;
  logic                 i_reset = 1'b1;
  logic                 i_start = 1'b0;
  logic [R:0]           i_target_duty = '0;
  logic [R-1:0]         i_step_size = '0;
  logic [HOLD_BITS-1:0] i_hold_periods = '0;
  logic                 i_abort = 1'b0;
  logic                 i_period_tick = 1'b0;
  logic [R:0]           o_duty;
  logic                 o_cmd_ready;
  logic                 o_busy;
  logic                 o_done;

  pwm_ramp_sequencer #(.R(R), .HOLD_BITS(HOLD_BITS)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_target_duty  (i_target_duty),
    .i_step_size    (i_step_size),
    .i_hold_periods (i_hold_periods),
    .i_abort        (i_abort),
    .i_period_tick  (i_period_tick),
    .o_duty         (o_duty),
    .o_cmd_ready    (o_cmd_ready),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  // Reference model state
  int m_duty = 0, m_busy = 0, m_done = 0, m_fin = 0;
  int m_tgt = 0, m_step = 1, m_hold = 1, m_d0 = 0, m_ticks = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock: update the model with the values sampled at the edge, then check.
  task automatic step_clk();
    int k, d;
    @(posedge i_clk);
    if (i_reset) begin
      m_duty = 0; m_busy = 0; m_done = 0; m_fin = 0;
    end else begin
      m_done = 0;
      if (m_busy == 0) begin
        if (i_start && !i_abort) begin
          m_tgt   = (int'(i_target_duty) > FULL) ? FULL : int'(i_target_duty);
          m_step  = (i_step_size == 0) ? 1 : int'(i_step_size);
          m_hold  = (i_hold_periods == 0) ? 1 : int'(i_hold_periods);
          m_d0    = m_duty;
          m_ticks = 0;
          m_busy  = 1;
          m_fin   = (m_tgt == m_duty) ? 1 : 0;
        end
      end else if (i_abort) begin
        m_busy = 0; m_fin = 0;
      end else if (m_fin != 0) begin
        m_done = 1; m_busy = 0; m_fin = 0;
      end else if (i_period_tick) begin
        m_ticks++;
        k = m_ticks / m_hold;
        if (m_tgt > m_d0) d = (m_d0 + k * m_step > m_tgt) ? m_tgt : m_d0 + k * m_step;
        else              d = (m_d0 - k * m_step < m_tgt) ? m_tgt : m_d0 - k * m_step;
        m_duty = d;
        if (d == m_tgt) m_fin = 1;
      end
    end
    @(negedge i_clk);
    if (o_done) n_done++;
    check("duty", int'(o_duty), m_duty);
    check("busy", int'(o_busy), m_busy);
    check("cmd_ready", int'(o_cmd_ready), (m_busy == 0) ? 1 : 0);
    check("done", int'(o_done), m_done);
  endtask

  task automatic cyc(input logic st, input logic ab, input logic tk);
    i_start = st; i_abort = ab; i_period_tick = tk;
    step_clk();
    i_start = 1'b0; i_abort = 1'b0; i_period_tick = 1'b0;
  endtask

  task automatic set_cmd(input int tgt, input int stp, input int hld);
    i_target_duty  = (R+1)'(tgt);
    i_step_size    = R'(stp);
    i_hold_periods = HOLD_BITS'(hld);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step_clk();
    i_reset = 1'b0;
  endtask

  initial begin
    int d0;
    do_reset();
    do_reset();
    check("reset_duty", int'(o_duty), 0);
    check("reset_ready", int'(o_cmd_ready), 1);

    // 1: 0 -> 64 by 16, hold 2
    set_cmd(64, 16, 2);
    cyc(1, 0, 0);
    for (int i = 0; i < 8; i++) begin cyc(0, 0, 1); cyc(0, 0, 0); end
    cyc(0, 0, 0);
    check("t1_final", int'(o_duty), 64);

    // 2: 64 -> 0 by 50, no underflow
    n_done = 0;
    set_cmd(0, 50, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    check("t2_tick1", int'(o_duty), 14);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("t2_final", int'(o_duty), 0);
    check("t2_done_cnt", n_done, 1);

    // 3: target clamps to full-on
    set_cmd(300, 255, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    check("t3_tick1", int'(o_duty), 255);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("t3_final", int'(o_duty), FULL);

    // 4: start while busy ignored, abort at 32
    do_reset();
    n_done = 0;
    set_cmd(128, 16, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    set_cmd(0, 200, 5);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    check("t4_duty", int'(o_duty), 32);
    check("t4_busy", int'(o_busy), 0);
    check("t4_done_cnt", n_done, 0);

    // 5: target == duty, then step=0/hold=0 behave as 1
    set_cmd(32, 0, 0);
    cyc(1, 0, 0);
    check("t5_busy", int'(o_busy), 1);
    cyc(0, 0, 0);
    check("t5_done", int'(o_done), 1);
    set_cmd(35, 0, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1);
    check("t5_final", int'(o_duty), 35);

    // 6: reset mid-ramp at 48
    do_reset();
    set_cmd(200, 16, 1);
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    check("t6_pre", int'(o_duty), 48);
    do_reset();
    check("t6_reset", int'(o_duty), 0);
    set_cmd(16, 16, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("t6_after", int'(o_duty), 16);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      i_reset = ($urandom_range(0, 299) == 0);
      d0 = int'($urandom_range(0, 3));
      set_cmd(int'($urandom_range(0, 511)),
              (d0 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20)),
              int'($urandom_range(0, 3)));
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 2) != 0));
      i_reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
